// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
interface apb_slave_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STR_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned SEL_WIDTH  = 1
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [SEL_WIDTH-1:0]  PSEL;
    logic                  PWRITE;
    logic                  PENABLE;
    logic [STR_WIDTH-1:0]  PSTROBE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        output PADDR, PWDATA, PSEL, PWRITE, PENABLE, PSTROBE,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PSEL, PWRITE, PENABLE, PSTROBE,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a word register file with byte-strobe writes
// and a fixed number of wait states per ACCESS phase.
module apb_slave_regfile #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STR_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned SEL_WIDTH   = 1,
    parameter int unsigned SLV_ID      = 0,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    apb_slave_regfile_if.slave   apb
);
    localparam int unsigned LANE_BITS = (STR_WIDTH > 1) ? $clog2(STR_WIDTH) : 0;
    localparam int unsigned IDX_W     = ADDR_WIDTH - LANE_BITS;
    localparam int unsigned MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_c, idx_q, rd_idx;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STR_WIDTH-1:0]  strb_q;
    logic [3:0]            cnt_q;
    logic                  pready_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic sel, pen;
    logic capture, dec, ready_set, ready_clr, load_rd, commit;
    logic unused_bits;

    function automatic logic in_range(input logic [IDX_W-1:0] i);
        return 32'(i) < MEM_DEPTH;
    endfunction

    assign sel         = apb.PSEL[SLV_ID];
    assign pen         = apb.PENABLE;
    assign idx_c       = apb.PADDR[ADDR_WIDTH-1:LANE_BITS];
    assign unused_bits = ^{apb.PSEL, apb.PADDR};

    // In IDLE the read port looks at the live SETUP address (zero-wait reads);
    // in ACCESS it uses the address captured at SETUP.
    assign rd_idx  = (state_q == IDLE) ? idx_c : idx_q;
    assign rd_data = in_range(rd_idx) ? mem[rd_idx[MEM_AW-1:0]] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel && !pen) state_d = ACCESS;
            ACCESS:  if (!(sel && pen) || pready_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture   = 1'b0;
        dec       = 1'b0;
        ready_set = 1'b0;
        ready_clr = 1'b0;
        load_rd   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !pen) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        ready_set = 1'b1;
                        load_rd   = !apb.PWRITE;
                    end
                end
            end
            ACCESS: begin
                if (sel && pen) begin
                    if (!pready_q) begin
                        dec = 1'b1;
                        if (cnt_q == 4'd1) begin
                            ready_set = 1'b1;
                            load_rd   = !wr_q;
                        end
                    end else begin
                        commit    = wr_q;
                        ready_clr = 1'b1;
                    end
                end else begin
                    ready_clr = 1'b1;
                end
            end
            default: ready_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
            prdata_q <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                idx_q   <= idx_c;
                wr_q    <= apb.PWRITE;
                wdata_q <= apb.PWDATA;
                strb_q  <= apb.PSTROBE;
                cnt_q   <= CNT_INIT;
            end
            if (dec) cnt_q <= cnt_q - 4'd1;
            if (ready_set)      pready_q <= 1'b1;
            else if (ready_clr) pready_q <= 1'b0;
            if (load_rd) prdata_q <= rd_data;
            if (commit && in_range(idx_q)) begin
                for (int unsigned b = 0; b < STR_WIDTH; b++) begin
                    if (strb_q[b]) mem[idx_q[MEM_AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign apb.PRDATA = prdata_q;
    assign apb.PREADY = pready_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three register files with 0, 2 and 3 wait states; the
// stimulus queues expected PRDATA/wait counts, a monitor checks each PREADY.
module tb_apb_slave_regfile;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int SELW = 2;

    typedef struct {
        int          dut;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst2, rst3;
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt[4];

    always #5 clk = ~clk;

    apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STR_WIDTH(SW), .SEL_WIDTH(SELW)) if0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STR_WIDTH(SW), .SEL_WIDTH(SELW)) if2 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STR_WIDTH(SW), .SEL_WIDTH(SELW)) if3 ();

    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STR_WIDTH(SW), .SEL_WIDTH(SELW),
                        .SLV_ID(0), .MEM_DEPTH(16), .WAIT_CYCLES(0))
        dut0 (.clk(clk), .reset(rst0), .apb(if0));
    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STR_WIDTH(SW), .SEL_WIDTH(SELW),
                        .SLV_ID(0), .MEM_DEPTH(16), .WAIT_CYCLES(2))
        dut2 (.clk(clk), .reset(rst2), .apb(if2));
    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STR_WIDTH(SW), .SEL_WIDTH(SELW),
                        .SLV_ID(0), .MEM_DEPTH(16), .WAIT_CYCLES(3))
        dut3 (.clk(clk), .reset(rst3), .apb(if3));

    function automatic logic rdy(input int d);
        case (d)
            0:       return if0.PREADY;
            2:       return if2.PREADY;
            default: return if3.PREADY;
        endcase
    endfunction

    function automatic logic [31:0] rdat(input int d);
        case (d)
            0:       return if0.PRDATA;
            2:       return if2.PRDATA;
            default: return if3.PRDATA;
        endcase
    endfunction

    function automatic logic sel0(input int d);
        case (d)
            0:       return if0.PSEL[0];
            2:       return if2.PSEL[0];
            default: return if3.PSEL[0];
        endcase
    endfunction

    function automatic logic pen(input int d);
        case (d)
            0:       return if0.PENABLE;
            2:       return if2.PENABLE;
            default: return if3.PENABLE;
        endcase
    endfunction

    function automatic logic rstv(input int d);
        case (d)
            0:       return rst0;
            2:       return rst2;
            default: return rst3;
        endcase
    endfunction

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic set_bus(input int d, input logic [1:0] sel, input logic en, input logic wr,
                           input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        case (d)
            0: begin
                if0.PSEL = sel; if0.PENABLE = en; if0.PWRITE = wr;
                if0.PADDR = addr; if0.PWDATA = data; if0.PSTROBE = strb;
            end
            2: begin
                if2.PSEL = sel; if2.PENABLE = en; if2.PWRITE = wr;
                if2.PADDR = addr; if2.PWDATA = data; if2.PSTROBE = strb;
            end
            default: begin
                if3.PSEL = sel; if3.PENABLE = en; if3.PWRITE = wr;
                if3.PADDR = addr; if3.PWDATA = data; if3.PSTROBE = strb;
            end
        endcase
    endtask

    task automatic idle(input int d);
        set_bus(d, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(posedge clk); #1;
    endtask

    // Full transfer; address/data/strobe are scrambled during ACCESS since
    // the completer must use what it captured in SETUP.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        e.dut = d; e.data = exp_rd; e.waits = d;
        sbq.push_back(e);
        set_bus(d, 2'b01, 1'b0, wr, addr, data, strb);
        @(posedge clk); #1;
        set_bus(d, 2'b01, 1'b1, wr, addr ^ 8'h04, ~data, ~strb);
        n = 0;
        while (!rdy(d) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy(d)) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_dut%0d addr 0x%02h: got no PREADY in 40 cycles, expected PREADY", d, addr);
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        int   d;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 0 : ((i == 1) ? 2 : 3);
            if (rstv(d)) begin
                cnt[d] = 0;
            end else begin
                if (sel0(d) && !pen(d)) cnt[d] = 0;
                else if (sel0(d) && pen(d) && !rdy(d)) cnt[d]++;
                if (rdy(d)) begin
                    if (sbq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_pready_dut%0d: got PREADY=1, expected no transfer", d);
                    end else begin
                        e = sbq.pop_front();
                        check($sformatf("dut_id_dut%0d", d), d, e.dut);
                        check($sformatf("prdata_dut%0d", d), rdat(d), e.data);
                        check($sformatf("waits_dut%0d", d), cnt[d], e.waits);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        set_bus(0, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        set_bus(2, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        set_bus(3, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_pready_dut0", 32'(if0.PREADY), 32'h0);
        check("reset_prdata_dut0", if0.PRDATA, 32'h0);
        check("reset_pready_dut2", 32'(if2.PREADY), 32'h0);
        check("reset_prdata_dut3", if3.PRDATA, 32'h0);
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;

        // Zero wait states
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0000_0000);
        idle(0);
        xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'b1111, 32'h0000_0000);
        idle(0);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 32'hDEADBEEF);
        idle(0);
        xfer(0, 1'b1, 8'h08, 32'h11223344, 4'b0101, 32'hDEADBEEF);
        idle(0);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 32'hDE22BE44);
        idle(0);
        xfer(0, 1'b1, 8'h00, 32'hA5A5A5A5, 4'hF, 32'hDE22BE44);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 32'hA5A5A5A5);
        idle(0);
        xfer(0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 32'hA5A5A5A5);
        idle(0);
        xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, 32'h0000_0000);
        idle(0);
        xfer(0, 1'b0, 8'h03, 32'h0, 4'h0, 32'hA5A5A5A5);
        idle(0);

        // Only a foreign PSEL bit: must be ignored entirely
        set_bus(0, 2'b10, 1'b0, 1'b1, 8'h00, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("foreign_psel_setup_pready", 32'(if0.PREADY), 32'h0);
        set_bus(0, 2'b10, 1'b1, 1'b1, 8'h00, 32'h0, 4'hF);
        repeat (2) begin
            @(posedge clk); #1;
            check("foreign_psel_access_pready", 32'(if0.PREADY), 32'h0);
        end
        idle(0);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 32'hA5A5A5A5);
        idle(0);

        // Two wait states
        xfer(2, 1'b1, 8'h08, 32'h0BADF00D, 4'hF, 32'h0000_0000);
        idle(2);
        xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, 32'h0BADF00D);
        idle(2);

        // Three wait states: reset in the middle of a write
        xfer(3, 1'b1, 8'h0C, 32'h12345678, 4'hF, 32'h0000_0000);
        idle(3);
        xfer(3, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h12345678);
        idle(3);
        set_bus(3, 2'b01, 1'b0, 1'b1, 8'h04, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        set_bus(3, 2'b01, 1'b1, 1'b1, 8'h04, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        check("midreset_pready", 32'(if3.PREADY), 32'h0);
        check("midreset_prdata", if3.PRDATA, 32'h0);
        rst3 = 1'b0;
        idle(3);
        xfer(3, 1'b0, 8'h04, 32'h0, 4'h0, 32'h0000_0000);
        idle(3);
        xfer(3, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0000_0000);
        idle(3);

        // Three wait states: PENABLE dropped mid-wait aborts the write
        xfer(3, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 32'h0000_0000);
        idle(3);
        xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, 32'hCAFEF00D);
        idle(3);
        set_bus(3, 2'b01, 1'b0, 1'b1, 8'h08, 32'h00000000, 4'hF);
        @(posedge clk); #1;
        set_bus(3, 2'b01, 1'b1, 1'b1, 8'h08, 32'h00000000, 4'hF);
        @(posedge clk); #1;
        set_bus(3, 2'b01, 1'b0, 1'b1, 8'h08, 32'h00000000, 4'hF);
        @(posedge clk); #1;
        check("abort_pready", 32'(if3.PREADY), 32'h0);
        check("abort_prdata", if3.PRDATA, 32'hCAFEF00D);
        idle(3);
        xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, 32'hCAFEF00D);
        idle(3);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (slave) end of the team's APB interface: responds to the PADDR/PWDATA/PSEL/PWRITE/PENABLE/PSTROBE driven by the master, and returns PRDATA/PREADY.
- Backs a word-organised register file with byte-strobe writes and a programmable number of wait states.
- Serves as the DUT-side responder for the APB agent and as a reusable peripheral register bank.

Parameters:
- ADDR_WIDTH, 8, width of PADDR (byte address).
- DATA_WIDTH, 32, width of PWDATA/PRDATA; multiple of 8.
- STR_WIDTH, DATA_WIDTH/8, width of PSTROBE, one bit per byte lane.
- SEL_WIDTH, 1, width of the PSEL bus.
- SLV_ID, 0, index of the PSEL bit that selects this slave.
- MEM_DEPTH, 16, number of DATA_WIDTH-bit words.
- WAIT_CYCLES, 0, PREADY-low cycles inserted in every ACCESS phase (0..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous active-high reset.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PSEL  input  SEL_WIDTH  slave selects; only bit SLV_ID is used.
- PWRITE  input  1  1=write, 0=read.
- PENABLE  input  1  marks the ACCESS phase.
- PSTROBE  input  STR_WIDTH  write byte-lane enables.
- PRDATA  output  DATA_WIDTH  read data, registered.
- PREADY  output  1  transfer-complete, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset effects: PREADY=0, PRDATA=0, FSM=IDLE, wait counter=0, all memory words=0.
- Reset asserted mid-transfer aborts the transfer; a pending write is not committed.
- Terms: sel = PSEL[SLV_ID]. idx = PADDR >> log2(STR_WIDTH). The address is in range when idx < MEM_DEPTH. The low PADDR bits are ignored.
- FSM states: IDLE, ACCESS.
- IDLE to ACCESS: on a clock edge with sel=1 and PENABLE=0 (SETUP phase).
  - Capture idx, PWRITE, PWDATA and PSTROBE.
  - Set cnt <= WAIT_CYCLES.
  - If WAIT_CYCLES=0: set PREADY<=1. For a read, also set PRDATA <= mem[idx], or 0 when out of range.
  - If WAIT_CYCLES>0: set PREADY<=0.
- In IDLE, any other input combination leaves the block in IDLE with PREADY=0.
- ACCESS with PREADY=0 and sel=1, PENABLE=1: decrement cnt.
  - When cnt reaches 1 (the last wait), set PREADY<=1 and, for a read, load PRDATA as above.
  - Net effect: exactly WAIT_CYCLES ACCESS cycles with PREADY=0, then one cycle with PREADY=1.
- ACCESS with PREADY=1 and sel=1, PENABLE=1 (completion edge):
  - For a write, commit every lane b where captured PSTROBE[b]=1: mem[idx][8b+7:8b] <= PWDATA lane.
  - Lanes with strobe 0 are unchanged.
  - Out-of-range writes are dropped silently.
  - Then PREADY<=0 and go to IDLE.
- Protocol violation: in ACCESS with sel=0 or PENABLE=0, abort. PREADY<=0, go to IDLE, no write, PRDATA unchanged.
- Back-to-back transfers: the master's next SETUP arrives in the cycle after completion, while the FSM is in IDLE. No idle cycle is required between transfers; throughput is one transfer per 2+WAIT_CYCLES clocks.
- PRDATA rules:
  - Changes only at a read's PREADY-rising edge and holds its value until the next read.
  - Writes never alter PRDATA.
  - PSTROBE is ignored for reads.
- Read-after-write to the same idx in consecutive transfers returns the newly written data.
- PSEL bits other than SLV_ID are ignored.
- PWDATA and PADDR are captured in SETUP, so later changes during ACCESS have no effect.

Test Plan:
- Reset then read idx 3 (PADDR=0x0C), WAIT_CYCLES=0 -> PREADY high in first ACCESS cycle, PRDATA=0x00000000; after reset PREADY=0, PRDATA=0.
- Write PADDR=0x08, PWDATA=0xDEADBEEF, PSTROBE=4'b1111, then read 0x08 -> PRDATA=0xDEADBEEF.
- Then write 0x08 with PWDATA=0x11223344, PSTROBE=4'b0101, then read -> PRDATA=0xDE22BE44.
- WAIT_CYCLES=2, read 0x08 -> exactly 2 ACCESS cycles with PREADY=0, then PREADY=1 with data; total 4 clocks from SETUP.
- Write PADDR=0x40 (idx 16, out of range), PSTROBE=4'hF -> completes normally, no memory word changes. Read 0x40 -> PRDATA=0.
- WAIT_CYCLES=3: assert reset during the second wait cycle of a write to 0x04 -> PREADY=0 and PRDATA=0 next cycle, mem[1] stays 0. Separately, drop PENABLE mid-wait -> abort, no write, FSM in IDLE.
- Back-to-back write 0x00 = 0xA5A5A5A5 then read 0x00 with no idle cycle (WAIT_CYCLES=0) -> read returns 0xA5A5A5A5.
- PSEL[SLV_ID]=0 with another PSEL bit set -> PREADY stays 0.
